// File: rtl/mem_interface.sv
// Memory-side access stage between the MAR/MDR and a synchronous single-port RAM.
// Handles one read or write at a time, with a programmable number of RAM wait states.
module mem_interface #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [31:0]           mar_q,
  input  logic [31:0]           mdr_q,
  input  logic                  read_req,
  input  logic                  write_req,
  output logic [31:0]           mdatain,
  output logic                  mdr_load,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  err,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [31:0]           mdatain_next;
  logic                  mdr_load_next;
  logic                  mem_ready_next;
  logic                  busy_next;
  logic                  err_next;
  logic                  ram_en_next;
  logic                  ram_we_next;
  logic [ADDR_WIDTH-1:0] ram_addr_next;
  logic [31:0]           ram_wdata_next;

  // Upper MAR bits are deliberately ignored.
  generate
    if (ADDR_WIDTH < 32) begin : g_unused_mar
      logic unused_mar_bits;
      assign unused_mar_bits = ^mar_q[31:ADDR_WIDTH];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    mdatain_next   = mdatain;
    mdr_load_next  = 1'b0;
    mem_ready_next = 1'b0;
    err_next       = 1'b0;
    ram_en_next    = ram_en;
    ram_we_next    = ram_we;
    ram_addr_next  = ram_addr;
    ram_wdata_next = ram_wdata;

    case (state_reg)
      IDLE: begin
        if (read_req && write_req) begin
          err_next = 1'b1;
        end else if (read_req || write_req) begin
          ram_addr_next = mar_q[ADDR_WIDTH-1:0];
          ram_en_next   = 1'b1;
          ram_we_next   = write_req;
          if (write_req) begin
            ram_wdata_next = mdr_q;
          end
          cnt_next   = CW'(WAIT_STATES);
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          // ram_we still tells us which kind of access is finishing.
          state_next     = DONE;
          ram_en_next    = 1'b0;
          ram_we_next    = 1'b0;
          mem_ready_next = 1'b1;
          if (!ram_we) begin
            mdatain_next  = ram_rdata;
            mdr_load_next = 1'b1;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next  = IDLE;
        ram_en_next = 1'b0;
        ram_we_next = 1'b0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mdatain   <= '0;
      mdr_load  <= 1'b0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mdatain   <= mdatain_next;
      mdr_load  <= mdr_load_next;
      mem_ready <= mem_ready_next;
      busy      <= busy_next;
      err       <= err_next;
      ram_en    <= ram_en_next;
      ram_we    <= ram_we_next;
      ram_addr  <= ram_addr_next;
      ram_wdata <= ram_wdata_next;
    end
  end

endmodule

// File: tb/tb_mem_interface.sv
// Randomized bench for mem_interface against a transaction-level timing/memory model.
// A small synchronous RAM model sits behind the DUT's RAM port.
module tb_mem_interface;

  localparam int AW = 9;
  localparam int WS = 2;

  logic          clk = 1'b0;
  logic          clr;
  logic [31:0]   mar_q, mdr_q;
  logic          read_req, write_req;
  logic [31:0]   mdatain;
  logic          mdr_load, mem_ready, busy, err;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [31:0]   ram_mem [0:(1<<AW)-1];

  logic [31:0]   ref_mem [0:(1<<AW)-1];
  logic [31:0]   exp_mdatain;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  mem_interface #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .clr(clr), .mar_q(mar_q), .mdr_q(mdr_q),
    .read_req(read_req), .write_req(write_req),
    .mdatain(mdatain), .mdr_load(mdr_load), .mem_ready(mem_ready),
    .busy(busy), .err(err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous RAM; the ld port preloads contents while the DUT is held in reset.
  always @(posedge clk) begin
    if (ld_en) begin
      ram_mem[ld_addr] <= ld_data;
    end else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Checks every cycle of an access that was accepted at the preceding rising edge.
  task automatic follow(input bit w, input logic [AW-1:0] a, input logic [31:0] d, input bit noisy);
    logic [31:0] rd;
    rd = ref_mem[a];
    for (int k = 0; k <= WS + 2; k++) begin
      @(negedge clk);
      if (k <= WS) begin
        check("acc_en", 32'(ram_en), 32'd1);
        check("acc_we", 32'(ram_we), 32'(w));
        check("acc_addr", 32'(ram_addr), 32'(a));
        if (w) check("acc_wdata", ram_wdata, d);
        check("acc_rdy", 32'(mem_ready), 32'd0);
        check("acc_load", 32'(mdr_load), 32'd0);
        check("acc_busy", 32'(busy), 32'd1);
      end else if (k == WS + 1) begin
        if (!w) exp_mdatain = rd;
        check("done_rdy", 32'(mem_ready), 32'd1);
        check("done_load", 32'(mdr_load), 32'(!w));
        check("done_en", 32'(ram_en), 32'd0);
        check("done_we", 32'(ram_we), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
      end else begin
        check("idle_rdy", 32'(mem_ready), 32'd0);
        check("idle_load", 32'(mdr_load), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_en", 32'(ram_en), 32'd0);
      end
      check("mdatain", mdatain, exp_mdatain);
      check("err", 32'(err), 32'd0);
      if (noisy && k <= WS) begin
        read_req  = 1'($urandom_range(0, 1));
        write_req = 1'b1;
        mar_q     = $urandom;
        mdr_q     = $urandom;
      end else begin
        read_req  = 1'b0;
        write_req = 1'b0;
      end
    end
    if (w) ref_mem[a] = d;
    $display("op %s addr=%h data=%h noisy=%0d", w ? "wr" : "rd", a, w ? d : rd, noisy);
  endtask

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [31:0] d, input bit noisy);
    @(negedge clk);
    mar_q     = ($urandom & ~32'((1 << AW) - 1)) | 32'(a);
    mdr_q     = w ? d : $urandom;
    read_req  = !w;
    write_req = w;
    @(posedge clk);
    follow(w, a, d, noisy);
  endtask

  task automatic conflict();
    @(negedge clk);
    mar_q = $urandom;
    read_req = 1'b1;
    write_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("cf_err", 32'(err), 32'd1);
    check("cf_busy", 32'(busy), 32'd0);
    check("cf_en", 32'(ram_en), 32'd0);
    read_req = 1'b0;
    write_req = 1'b0;
    @(negedge clk);
    check("cf_err_clear", 32'(err), 32'd0);
    check("cf_en2", 32'(ram_en), 32'd0);
    check("cf_busy2", 32'(busy), 32'd0);
    $display("op conflict err pulse");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"}, 32'(ram_en), 32'd0);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_wdata"}, ram_wdata, 32'd0);
    check({tag, "_mdatain"}, mdatain, 32'd0);
    check({tag, "_load"}, 32'(mdr_load), 32'd0);
    check({tag, "_rdy"}, 32'(mem_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    clr = 1'b1;
    mar_q = '0;
    mdr_q = '0;
    read_req = 1'b0;
    write_req = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    exp_mdatain = '0;

    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = AW'(i);
      ld_data = (i == 5) ? 32'hDEAD_BEEF : $urandom;
      ref_mem[i] = ld_data;
    end
    @(negedge clk);
    ld_en = 1'b0;
    check_all_zero("por");
    clr = 1'b0;

    // Directed read of word 5, then write and read-back of 0x10.
    issue(1'b0, AW'(5), 32'd0, 1'b0);
    issue(1'b1, AW'(16), 32'h1234_5678, 1'b0);
    issue(1'b0, AW'(16), 32'd0, 1'b0);
    conflict();
    issue(1'b0, AW'(5), 32'd0, 1'b1);

    // Reset held with a pending read, then released into a fresh accept.
    @(negedge clk);
    mar_q = 32'h0000_0005;
    read_req = 1'b1;
    clr = 1'b1;
    exp_mdatain = '0;
    #1 check_all_zero("rst0");
    repeat (2) begin
      @(negedge clk);
      check_all_zero("rst");
    end
    clr = 1'b0;
    @(posedge clk);
    follow(1'b0, AW'(5), 32'd0, 1'b0);

    // Abort two cycles into a read of word 7.
    @(negedge clk);
    mar_q = 32'h0000_0007;
    read_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    read_req = 1'b0;
    check("ab_en_pre", 32'(ram_en), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    exp_mdatain = '0;
    #1;
    check("ab_en", 32'(ram_en), 32'd0);
    check("ab_we", 32'(ram_we), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_mdatain", mdatain, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    repeat (WS + 3) begin
      @(negedge clk);
      check("ab_rdy", 32'(mem_ready), 32'd0);
      check("ab_load", 32'(mdr_load), 32'd0);
      check("ab_busy2", 32'(busy), 32'd0);
    end
    $display("op abort read addr=007");
    issue(1'b0, AW'(5), 32'd0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        conflict();
      end else begin
        issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, (1 << AW) - 1)),
              $urandom, 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
